// File: rtl/hcp_frame_dispatch.sv
// Purpose : routes frames from the HCP frame-parse stage by ethertype. TSMP frames go to the
//           decapsulation port. ARP/PTP frames go to the encapsulation port with their receive
//           timestamp and a type tag. All other frames are dropped. The block also guards frame
//           length and keeps per-class frame/error counters.
// Ports   : i_clk/i_rst_n (async active-low reset);
//           iv_data/iv_descriptor/i_data_wr  byte stream in (descriptor valid on first byte only);
//           ov_tsmp_data/o_tsmp_data_wr      decapsulation port (1-cycle latency, registered);
//           ov_encap_data/o_encap_data_wr/ov_encap_ts/ov_encap_type  encapsulation port;
//           ov_*_cnt                         16-bit wrapping statistics;
//           ov_disp_state                    FSM state for debug.
module hcp_frame_dispatch #(
  parameter logic [11:0] MAX_LEN   = 12'd1536,
  parameter logic [15:0] TSMP_TYPE = 16'h1662
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [8:0]  iv_data,
  input  logic [34:0] iv_descriptor,
  input  logic        i_data_wr,
  output logic [8:0]  ov_tsmp_data,
  output logic        o_tsmp_data_wr,
  output logic [8:0]  ov_encap_data,
  output logic        o_encap_data_wr,
  output logic [18:0] ov_encap_ts,
  output logic [1:0]  ov_encap_type,
  output logic [15:0] ov_tsmp_cnt,
  output logic [15:0] ov_encap_cnt,
  output logic [15:0] ov_discard_cnt,
  output logic [15:0] ov_err_cnt,
  output logic [1:0]  ov_disp_state
);

  localparam logic [1:0] IDLE_S  = 2'd0;
  localparam logic [1:0] TSMP_S  = 2'd1;
  localparam logic [1:0] ENCAP_S = 2'd2;
  localparam logic [1:0] DISC_S  = 2'd3;

  localparam logic [15:0] ARP_TYPE = 16'h0806;
  localparam logic [15:0] PTP_TYPE = 16'h88F7;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [11:0] byte_cnt_q;
  logic [11:0] byte_cnt_d;

  logic [15:0] ethertype;
  logic        is_tsmp;
  logic        is_encap;
  logic        is_end;
  logic        at_max;

  // Per-cycle actions decided by the output process, applied by the datapath register.
  logic        fwd_tsmp;
  logic        fwd_encap;
  logic [8:0]  fwd_dat;
  logic        ts_ld;
  logic        frame_done;
  logic        err_inc;
  logic        disc_inc;

  assign ethertype = iv_descriptor[15:0];
  assign is_tsmp   = (ethertype == TSMP_TYPE);
  assign is_encap  = (ethertype == ARP_TYPE) || (ethertype == PTP_TYPE);
  assign is_end    = iv_data[8];
  // byte_cnt_q holds the bytes already taken; the current byte is number byte_cnt_q+1.
  assign at_max    = ((byte_cnt_q + 12'd1) == MAX_LEN);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE_S;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_S: begin
        if (i_data_wr) begin
          if (is_tsmp)       state_d = TSMP_S;
          else if (is_encap) state_d = ENCAP_S;
          else               state_d = DISC_S;
        end
      end
      TSMP_S, ENCAP_S: begin
        // End byte wins over oversize when both fall on byte MAX_LEN.
        if (!i_data_wr || is_end) state_d = IDLE_S;
        else if (at_max)          state_d = DISC_S;
      end
      DISC_S: begin
        if (!i_data_wr || is_end) state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    fwd_tsmp   = 1'b0;
    fwd_encap  = 1'b0;
    fwd_dat    = iv_data;
    ts_ld      = 1'b0;
    frame_done = 1'b0;
    err_inc    = 1'b0;
    disc_inc   = 1'b0;
    byte_cnt_d = byte_cnt_q;
    case (state_q)
      IDLE_S: begin
        if (i_data_wr) begin
          // The first byte starts a frame whatever its marker bit says.
          byte_cnt_d = 12'd1;
          fwd_tsmp   = is_tsmp;
          fwd_encap  = !is_tsmp && is_encap;
          ts_ld      = !is_tsmp && is_encap;
          disc_inc   = !is_tsmp && !is_encap;
        end
      end
      TSMP_S, ENCAP_S: begin
        if (i_data_wr) begin
          byte_cnt_d = byte_cnt_q + 12'd1;
          fwd_tsmp   = (state_q == TSMP_S);
          fwd_encap  = (state_q == ENCAP_S);
          if (is_end) begin
            frame_done = 1'b1;
          end else if (at_max) begin
            // Cut the frame here: close it downstream with a forced end marker.
            frame_done = 1'b1;
            err_inc    = 1'b1;
            fwd_dat    = {1'b1, iv_data[7:0]};
          end
        end else begin
          // Truncated frame: what has gone out stands, no marker is synthesised.
          err_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------- Registered datapath and counters ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_cnt_q      <= '0;
      o_tsmp_data_wr  <= 1'b0;
      ov_tsmp_data    <= '0;
      o_encap_data_wr <= 1'b0;
      ov_encap_data   <= '0;
      ov_encap_ts     <= '0;
      ov_encap_type   <= '0;
      ov_tsmp_cnt     <= '0;
      ov_encap_cnt    <= '0;
      ov_discard_cnt  <= '0;
      ov_err_cnt      <= '0;
    end else begin
      byte_cnt_q      <= byte_cnt_d;
      o_tsmp_data_wr  <= fwd_tsmp;
      ov_tsmp_data    <= fwd_tsmp ? fwd_dat : 9'd0;
      o_encap_data_wr <= fwd_encap;
      ov_encap_data   <= fwd_encap ? fwd_dat : 9'd0;
      // Timestamp/type persist after the frame until the next encap frame starts.
      if (ts_ld) begin
        ov_encap_ts   <= iv_descriptor[34:16];
        ov_encap_type <= (ethertype == PTP_TYPE) ? 2'd1 : 2'd0;
      end
      if (frame_done && (state_q == TSMP_S))  ov_tsmp_cnt  <= ov_tsmp_cnt + 16'd1;
      if (frame_done && (state_q == ENCAP_S)) ov_encap_cnt <= ov_encap_cnt + 16'd1;
      if (disc_inc) ov_discard_cnt <= ov_discard_cnt + 16'd1;
      if (err_inc)  ov_err_cnt     <= ov_err_cnt + 16'd1;
    end
  end

  assign ov_disp_state = state_q;

endmodule

// File: tb/tb_hcp_frame_dispatch.sv
// Purpose : self-checking bench for hcp_frame_dispatch. A cycle table covers latency, routing and
//           FSM states; frame-level tasks plus a frame-level reference model cover long frames,
//           oversize, truncation, counter wrap, mid-frame reset and randomized traffic.
// Ports   : none (drives all DUT ports, clock period 10).
module tb_hcp_frame_dispatch;

  localparam logic [11:0] MAX_LEN  = 12'd1536;
  localparam logic [15:0] ET_TSMP  = 16'h1662;
  localparam logic [15:0] ET_ARP   = 16'h0806;
  localparam logic [15:0] ET_PTP   = 16'h88F7;
  localparam logic [15:0] ET_IPV4  = 16'h0800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  data = '0;
  logic [34:0] desc = '0;
  logic        wr = 1'b0;
  logic [8:0]  tsmp_data;
  logic        tsmp_wr;
  logic [8:0]  encap_data;
  logic        encap_wr;
  logic [18:0] encap_ts;
  logic [1:0]  encap_type;
  logic [15:0] tsmp_cnt, encap_cnt, discard_cnt, err_cnt;
  logic [1:0]  disp_state;

  always #5 clk = ~clk;

  hcp_frame_dispatch #(.MAX_LEN(MAX_LEN), .TSMP_TYPE(ET_TSMP)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .iv_data         (data),
    .iv_descriptor   (desc),
    .i_data_wr       (wr),
    .ov_tsmp_data    (tsmp_data),
    .o_tsmp_data_wr  (tsmp_wr),
    .ov_encap_data   (encap_data),
    .o_encap_data_wr (encap_wr),
    .ov_encap_ts     (encap_ts),
    .ov_encap_type   (encap_type),
    .ov_tsmp_cnt     (tsmp_cnt),
    .ov_encap_cnt    (encap_cnt),
    .ov_discard_cnt  (discard_cnt),
    .ov_err_cnt      (err_cnt),
    .ov_disp_state   (disp_state)
  );

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  // Reference model state: expected output streams and counter values.
  logic [8:0]  got_t[$], exp_t[$];
  logic [29:0] got_e[$], exp_e[$];
  logic [15:0] m_tsmp = '0, m_encap = '0, m_disc = '0, m_err = '0;
  logic [18:0] m_ts = '0;
  logic [1:0]  m_type = '0;

  typedef struct {
    logic        wr;
    logic [8:0]  dat;
    logic [15:0] et;
    logic [18:0] ts;
    logic        exp_twr;
    logic [8:0]  exp_tdat;
    logic        exp_ewr;
    logic [8:0]  exp_edat;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (tsmp_wr) got_t.push_back(tsmp_data);
    else if (tsmp_data != 9'd0) viol++;
    if (encap_wr) got_e.push_back({encap_type, encap_ts, encap_data});
    else if (encap_data != 9'd0) viol++;
    if (tsmp_wr && encap_wr) viol++;
  end

  // Drives one frame of len bytes (cut after trunc bytes when 0 < trunc < len) and
  // updates the frame-level model.
  task automatic send_frame(input int len, input logic [15:0] et, input logic [18:0] ts,
                            input int trunc);
    int  n_in;
    int  fwd;
    bit  trn, ovs, is_t, is_e;
    logic [8:0] b;
    n_in = (trunc > 0 && trunc < len) ? trunc : len;
    trn  = (n_in < len);
    ovs  = (len > int'(MAX_LEN)) && (n_in >= int'(MAX_LEN));
    fwd  = ovs ? int'(MAX_LEN) : n_in;
    is_t = (et == ET_TSMP);
    is_e = !is_t && (et == ET_ARP || et == ET_PTP);
    if (is_e) begin
      m_ts   = ts;
      m_type = (et == ET_PTP) ? 2'd1 : 2'd0;
    end
    for (int n = 1; n <= n_in; n++) begin
      b = {(n == 1 || n == len), 8'($urandom)};
      data = b;
      desc = (n == 1) ? {ts, et} : 35'({$urandom, $urandom});
      wr   = 1'b1;
      if (n <= fwd) begin
        if (is_t) exp_t.push_back({b[8] | (ovs && n == fwd), b[7:0]});
        if (is_e) exp_e.push_back({m_type, m_ts, b[8] | (ovs && n == fwd), b[7:0]});
      end
      tick();
    end
    wr = 1'b0; data = '0; desc = '0;
    if (!is_t && !is_e) m_disc++;
    else if (trn && !ovs) m_err++;
    else begin
      if (is_t) m_tsmp++;
      else      m_encap++;
      if (ovs)  m_err++;
    end
  endtask

  task automatic cmp_counters(input string name);
    check({name, "_tsmp_cnt"}, tsmp_cnt, m_tsmp);
    check({name, "_encap_cnt"}, encap_cnt, m_encap);
    check({name, "_discard_cnt"}, discard_cnt, m_disc);
    check({name, "_err_cnt"}, err_cnt, m_err);
    check({name, "_encap_ts"}, encap_ts, m_ts);
    check({name, "_encap_type"}, encap_type, m_type);
    check({name, "_state"}, disp_state, 2'd0);
  endtask

  // Lets the last output byte drain, then compares streams and counters.
  task automatic check_frame(input string name);
    int bad;
    tick();
    tick();
    check({name, "_tsmp_len"}, got_t.size(), exp_t.size());
    bad = 0;
    for (int i = 0; i < got_t.size() && i < exp_t.size(); i++)
      if (got_t[i] !== exp_t[i]) bad++;
    check({name, "_tsmp_bytes_bad"}, bad, 0);
    check({name, "_encap_len"}, got_e.size(), exp_e.size());
    bad = 0;
    for (int i = 0; i < got_e.size() && i < exp_e.size(); i++)
      if (got_e[i] !== exp_e[i]) bad++;
    check({name, "_encap_bytes_bad"}, bad, 0);
    got_t.delete(); exp_t.delete(); got_e.delete(); exp_e.delete();
    cmp_counters(name);
  endtask

  initial begin
    // Cycle table: each row is applied for one cycle; expectations are the registered
    // outputs right after that edge.
    vecs[0]  = '{1'b0, 9'h000, 16'h0000, 19'h0,     1'b0, 9'h000, 1'b0, 9'h000, 2'd0};
    vecs[1]  = '{1'b1, 9'h1AA, ET_TSMP,  19'h0,     1'b1, 9'h1AA, 1'b0, 9'h000, 2'd1};
    vecs[2]  = '{1'b1, 9'h055, 16'h0000, 19'h0,     1'b1, 9'h055, 1'b0, 9'h000, 2'd1};
    vecs[3]  = '{1'b1, 9'h1CC, 16'h0000, 19'h0,     1'b1, 9'h1CC, 1'b0, 9'h000, 2'd0};
    vecs[4]  = '{1'b1, 9'h101, ET_ARP,   19'h7,     1'b0, 9'h000, 1'b1, 9'h101, 2'd2};
    vecs[5]  = '{1'b1, 9'h102, 16'h0000, 19'h0,     1'b0, 9'h000, 1'b1, 9'h102, 2'd0};
    vecs[6]  = '{1'b1, 9'h133, ET_IPV4,  19'h0,     1'b0, 9'h000, 1'b0, 9'h000, 2'd3};
    vecs[7]  = '{1'b1, 9'h044, 16'h0000, 19'h0,     1'b0, 9'h000, 1'b0, 9'h000, 2'd3};
    vecs[8]  = '{1'b1, 9'h155, 16'h0000, 19'h0,     1'b0, 9'h000, 1'b0, 9'h000, 2'd0};
    vecs[9]  = '{1'b1, 9'h160, ET_PTP,   19'h5A5A5, 1'b0, 9'h000, 1'b1, 9'h160, 2'd2};
    vecs[10] = '{1'b0, 9'h000, 16'h0000, 19'h0,     1'b0, 9'h000, 1'b0, 9'h000, 2'd0};
    vecs[11] = '{1'b1, 9'h111, ET_TSMP,  19'h0,     1'b1, 9'h111, 1'b0, 9'h000, 2'd1};
    vecs[12] = '{1'b0, 9'h000, 16'h0000, 19'h0,     1'b0, 9'h000, 1'b0, 9'h000, 2'd0};
    vecs[13] = '{1'b1, 9'h122, 16'h1234, 19'h0,     1'b0, 9'h000, 1'b0, 9'h000, 2'd3};
    vecs[14] = '{1'b0, 9'h000, 16'h0000, 19'h0,     1'b0, 9'h000, 1'b0, 9'h000, 2'd0};

    // Reset state.
    #12;
    check("reset_outputs_nonzero", |{tsmp_data, tsmp_wr, encap_data, encap_wr, encap_ts,
                                     encap_type, tsmp_cnt, encap_cnt, discard_cnt, err_cnt,
                                     disp_state}, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      wr   = vecs[i].wr;
      data = vecs[i].dat;
      desc = {vecs[i].ts, vecs[i].et};
      tick();
      check($sformatf("vec%0d", i),
            {tsmp_wr, tsmp_data, encap_wr, encap_data, disp_state},
            {vecs[i].exp_twr, vecs[i].exp_tdat, vecs[i].exp_ewr, vecs[i].exp_edat,
             vecs[i].exp_st});
    end
    wr = 1'b0; data = '0; desc = '0;
    tick();
    // Table traffic: TSMP ok, ARP ok, two unknown frames, PTP and TSMP truncated.
    m_tsmp = 16'd1; m_encap = 16'd1; m_disc = 16'd2; m_err = 16'd2;
    m_ts = 19'h5A5A5; m_type = 2'd1;
    got_t.delete(); got_e.delete();
    cmp_counters("table");

    // Directed frames.
    send_frame(64, ET_TSMP, 19'h0, 0);       check_frame("tsmp64");
    send_frame(90, ET_PTP, 19'h12345, 0);    check_frame("ptp90");
    send_frame(60, ET_ARP, 19'h2BCDE, 0);    check_frame("arp60");
    send_frame(100, ET_IPV4, 19'h11111, 0);  check_frame("ipv4_100");
    send_frame(20, ET_TSMP, 19'h0, 0);       check_frame("tsmp_after_drop");
    send_frame(1600, ET_TSMP, 19'h0, 0);     check_frame("tsmp1600_oversize");
    send_frame(1536, ET_PTP, 19'h0ABCD, 0);  check_frame("ptp1536_exact");
    send_frame(1537, ET_ARP, 19'h00042, 0);  check_frame("arp1537_oversize");
    send_frame(100, ET_TSMP, 19'h0, 30);     check_frame("tsmp_trunc30");
    send_frame(2, ET_ARP, 19'h7FFFF, 0);     check_frame("arp_min");

    // Counter wrap: preload the TSMP counter, then forward one more frame.
    force dut.ov_tsmp_cnt = 16'hFFFF;
    #1;
    release dut.ov_tsmp_cnt;
    m_tsmp = 16'hFFFF;
    tick();
    check("preload_tsmp_cnt", tsmp_cnt, 16'hFFFF);
    send_frame(4, ET_TSMP, 19'h0, 0);        check_frame("tsmp_wrap");

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      int len, trunc, sel;
      logic [15:0] et;
      sel = $urandom_range(0, 4);
      case (sel)
        0: et = ET_TSMP;
        1: et = ET_ARP;
        2: et = ET_PTP;
        3: et = ET_IPV4;
        default: et = 16'($urandom);
      endcase
      len   = ($urandom_range(0, 7) == 0) ? $urandom_range(1520, 1560) : $urandom_range(2, 120);
      trunc = ($urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : 0;
      send_frame(len, et, 19'($urandom), trunc);
      check_frame($sformatf("rand%0d", k));
    end

    // Asynchronous reset in the middle of a TSMP frame.
    for (int n = 1; n <= 5; n++) begin
      data = {(n == 1), 8'(n)};
      desc = (n == 1) ? {19'h0, ET_TSMP} : '0;
      wr   = 1'b1;
      tick();
    end
    data = 9'h0AA;
    #2;
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs_nonzero",
          |{tsmp_data, tsmp_wr, encap_data, encap_wr, encap_ts, encap_type, tsmp_cnt,
            encap_cnt, discard_cnt, err_cnt, disp_state}, 1'b0);
    wr = 1'b0; data = '0;
    tick();
    rst_n = 1'b1;
    m_tsmp = '0; m_encap = '0; m_disc = '0; m_err = '0; m_ts = '0; m_type = '0;
    got_t.delete(); got_e.delete(); exp_t.delete(); exp_e.delete();
    tick();
    cmp_counters("after_reset");
    send_frame(10, ET_TSMP, 19'h0, 0);       check_frame("tsmp_after_reset");

    check("idle_data_or_dual_wr_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
